mem_write_b_ppx: RTL and testbench
==================================

MEM_WRITE_B_PPX -- requirements
Module: mem_write_b_ppx

Interface
REQ-001 SHALL have parameter N2, default 4: number of B banks; N2 >= 2, power of two.
REQ-002 SHALL have parameter MATRIXSIZE_W, default 16: width of size/count config inputs.
REQ-003 SHALL have parameter ADDR_W, default 12: bank address width; MSB selects ping/pong half, so each half holds 2**(ADDR_W-1) words.
REQ-004 SHALL have parameter DATA_W, default 8: element width.
REQ-005 SHALL have a single clock and a synchronous, active-high reset:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
REQ-006 SHALL have the following other ports:
- start  in  1  latch config, begin a run; honoured only in IDLE.
- M2  in  MATRIXSIZE_W  rows per block.
- BLOCK_WIDTHdN2  in  MATRIXSIZE_W  block width divided by N2.
- BLOCK_NUM  in  MATRIXSIZE_W  blocks per run.
- valid_B  in  1  input element valid.
- data_B  in  DATA_W  input element.
- ready_B  out  1  block can accept an element.
- buf_release  in  2  consumer frees ping (bit0) or pong (bit1) half.
- wr_addr_B  out  ADDR_W  bank write address.
- wr_data_B  out  DATA_W  bank write data.
- activate_B  out  N2  one-hot bank write enable.
- buf_done  out  2  one-cycle pulse: that half has been filled.
- busy  out  1  high outside IDLE.
- done  out  1  one-cycle pulse: last element of the run written.
- cfg_err  out  1  one-cycle pulse: start rejected.

Function
REQ-007 SHALL implement states IDLE, WRITE, WAIT_BUF.
REQ-008 SHALL, in IDLE on start, latch M2/BLOCK_WIDTHdN2/BLOCK_NUM, clear all counters, set buf_sel=0, and enter WRITE; later config changes SHALL be ignored until the next start.
REQ-009 SHALL reject start (stay IDLE, pulse cfg_err next cycle) if any config is 0 or M2*BLOCK_WIDTHdN2 > 2**(ADDR_W-1).
REQ-010 SHALL drive ready_B = 1 only in WRITE; a beat is accepted when valid_B && ready_B.
REQ-011 SHALL hold counters col (0..N2-1), phase (0..BLOCK_WIDTHdN2-1), row (0..M2-1), blk (0..BLOCK_NUM-1), nested in that order, col fastest; each accepted beat advances col, and carries propagate on wrap.
REQ-012 SHALL, one cycle after an accepted beat, drive wr_addr_B = {buf_sel, row + phase*M2} (low ADDR_W-1 bits), wr_data_B = data_B, and activate_B = one-hot(col), using counter values before the advance.
REQ-013 SHALL drive activate_B to 0 in any cycle following a non-accepted cycle; wr_addr_B/wr_data_B SHALL hold their last values.
REQ-014 SHALL pulse buf_done[buf_sel] one cycle after the last beat of a block (col, phase, row all at max) and set full[buf_sel], toggle buf_sel, and advance blk.
REQ-015 SHALL, after a block completes and blk was not the last, enter WRITE if full[new buf_sel]==0, else WAIT_BUF; WAIT_BUF SHALL move to WRITE in the cycle after full[buf_sel] clears.
REQ-016 SHALL clear full[i] on buf_release[i]; a release of a half that is not full SHALL be ignored; a release coinciding with the set of the other half SHALL apply both.
REQ-017 SHALL, on the last beat of the last block, pulse done together with buf_done and return to IDLE; full flags SHALL persist until released or reset.
REQ-018 SHALL throttle without loss: a gap in valid_B SHALL stall counters, and no beat SHALL be accepted in WAIT_BUF or IDLE.
REQ-019 SHALL use counter and address arithmetic of at least MATRIXSIZE_W bits, with the multiply realised as an incremental offset (+M2 per phase step, reset to 0 on phase wrap).

Reset
REQ-020 SHALL, on rst, force IDLE, all counters 0, buf_sel=0, full=00, ready_B=0, activate_B=0, wr_addr_B=0, wr_data_B=0, buf_done=00, done=0, busy=0, cfg_err=0, overriding any in-flight beat or start.

Verification
REQ-021 N2=4, M2=2, BLOCK_WIDTHdN2=2, BLOCK_NUM=1, continuous valid -> 16 writes; addr sequence 0x4,2x4,1x4,3x4; activate_B cycles 0001,0010,0100,1000; buf_done=01 and done pulse one cycle after 16th beat.
REQ-022 Same config, BLOCK_NUM=3, no release -> block 1 at addr 0x800+{0,2,1,3}; after block 1, WAIT_BUF with ready_B=0; buf_release=01 -> ready_B=1 next cycle, block 2 writes addr 0..3.
REQ-023 valid_B toggling every other cycle -> identical addr/activate sequence to REQ-021, with activate_B=0 in gap cycles.
REQ-024 start with M2=0, or M2=64 with BLOCK_WIDTHdN2=64 at ADDR_W=12 -> cfg_err pulse, busy stays 0.
REQ-025 rst asserted at beat 7 of a block -> all outputs zero next cycle; new start rewrites from addr 0, activate_B=0001.

Source files
------------

// File: rtl/mem_write_b_ppx.sv
// B-matrix bank writer: scatters a streamed block across N2 banks into a
// ping/pong buffer half, with back-pressure while the target half is still full.
module mem_write_b_ppx #(
    parameter int N2           = 4,
    parameter int MATRIXSIZE_W = 16,
    parameter int ADDR_W       = 12,
    parameter int DATA_W       = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [MATRIXSIZE_W-1:0] M2,
    input  logic [MATRIXSIZE_W-1:0] BLOCK_WIDTHdN2,
    input  logic [MATRIXSIZE_W-1:0] BLOCK_NUM,
    input  logic                    valid_B,
    input  logic [DATA_W-1:0]       data_B,
    output logic                    ready_B,
    input  logic [1:0]              buf_release,
    output logic [ADDR_W-1:0]       wr_addr_B,
    output logic [DATA_W-1:0]       wr_data_B,
    output logic [N2-1:0]           activate_B,
    output logic [1:0]              buf_done,
    output logic                    busy,
    output logic                    done,
    output logic                    cfg_err
);
    localparam int COL_W = $clog2(N2);
    localparam int MW    = MATRIXSIZE_W;
    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_WRITE    = 2'd1;
    localparam logic [1:0] S_WAIT_BUF = 2'd2;
    localparam logic [MW-1:0] ONE_M  = {{(MW-1){1'b0}}, 1'b1};
    localparam logic [MW-1:0] ZERO_M = {MW{1'b0}};
    localparam logic [2*MW-1:0] HALF_WORDS = {{(2*MW-1){1'b0}}, 1'b1} << (ADDR_W-1);

    function automatic logic [N2-1:0] f_onehot(input logic [COL_W-1:0] idx);
        logic [N2-1:0] v;
        v      = {N2{1'b0}};
        v[idx] = 1'b1;
        return v;
    endfunction

    logic [1:0]        r_state;
    logic [MW-1:0]     r_cfg_m2, r_cfg_bw, r_cfg_bn;
    logic [COL_W-1:0]  r_col;
    logic [MW-1:0]     r_phase, r_row, r_blk, r_off;
    logic              r_buf_sel;
    logic [1:0]        r_full;
    logic [1:0]        r_buf_done;
    logic              r_done, r_cfg_err;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [DATA_W-1:0] r_wr_data;
    logic [N2-1:0]     r_activate;

    logic              w_accept, w_last_col, w_last_phase, w_last_row, w_last_blk, w_blk_end;
    logic [1:0]        w_full_rel, w_set_mask;
    logic [MW-1:0]     w_sum;
    logic [ADDR_W-1:0] w_addr;
    logic [2*MW-1:0]   w_prod;
    logic              w_cfg_bad;

    assign w_accept     = valid_B && (r_state == S_WRITE);
    assign w_last_col   = (r_col == COL_W'(N2-1));
    assign w_last_phase = (r_phase == (r_cfg_bw - ONE_M));
    assign w_last_row   = (r_row == (r_cfg_m2 - ONE_M));
    assign w_last_blk   = (r_blk == (r_cfg_bn - ONE_M));
    assign w_blk_end    = w_accept && w_last_col && w_last_phase && w_last_row;
    assign w_full_rel   = r_full & ~buf_release;
    assign w_set_mask   = w_blk_end ? (r_buf_sel ? 2'b10 : 2'b01) : 2'b00;
    // r_off carries phase*M2, so the bank address needs only an adder
    assign w_sum        = r_row + r_off;
    assign w_addr       = {r_buf_sel, w_sum[ADDR_W-2:0]};
    assign w_prod       = {ZERO_M, M2} * {ZERO_M, BLOCK_WIDTHdN2};
    assign w_cfg_bad    = (M2 == ZERO_M) || (BLOCK_WIDTHdN2 == ZERO_M) ||
                          (BLOCK_NUM == ZERO_M) || (w_prod > HALF_WORDS);

    assign ready_B    = (r_state == S_WRITE);
    assign busy       = (r_state != S_IDLE);
    assign wr_addr_B  = r_wr_addr;
    assign wr_data_B  = r_wr_data;
    assign activate_B = r_activate;
    assign buf_done   = r_buf_done;
    assign done       = r_done;
    assign cfg_err    = r_cfg_err;

    // Control FSM, nested counters and ping/pong full tracking
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cfg_m2   <= ZERO_M;
            r_cfg_bw   <= ZERO_M;
            r_cfg_bn   <= ZERO_M;
            r_col      <= {COL_W{1'b0}};
            r_phase    <= ZERO_M;
            r_row      <= ZERO_M;
            r_blk      <= ZERO_M;
            r_off      <= ZERO_M;
            r_buf_sel  <= 1'b0;
            r_full     <= 2'b00;
            r_buf_done <= 2'b00;
            r_done     <= 1'b0;
            r_cfg_err  <= 1'b0;
        end else begin
            r_buf_done <= 2'b00;
            r_done     <= 1'b0;
            r_cfg_err  <= 1'b0;
            r_full     <= w_full_rel | w_set_mask;
            case (r_state)
                S_IDLE: begin
                    if (start && w_cfg_bad) begin
                        r_cfg_err <= 1'b1;
                    end else if (start) begin
                        r_cfg_m2  <= M2;
                        r_cfg_bw  <= BLOCK_WIDTHdN2;
                        r_cfg_bn  <= BLOCK_NUM;
                        r_col     <= {COL_W{1'b0}};
                        r_phase   <= ZERO_M;
                        r_row     <= ZERO_M;
                        r_blk     <= ZERO_M;
                        r_off     <= ZERO_M;
                        r_buf_sel <= 1'b0;
                        r_state   <= S_WRITE;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_WRITE: begin
                    if (w_accept) begin
                        r_col <= w_last_col ? {COL_W{1'b0}} : r_col + {{(COL_W-1){1'b0}}, 1'b1};
                        if (w_last_col && w_last_phase) begin
                            r_phase <= ZERO_M;
                            r_off   <= ZERO_M;
                            r_row   <= w_last_row ? ZERO_M : r_row + ONE_M;
                        end else if (w_last_col) begin
                            r_phase <= r_phase + ONE_M;
                            r_off   <= r_off + r_cfg_m2;
                        end else begin
                            r_phase <= r_phase;
                        end
                        if (w_blk_end) begin
                            r_buf_done[r_buf_sel] <= 1'b1;
                            r_buf_sel             <= ~r_buf_sel;
                            if (w_last_blk) begin
                                r_blk   <= ZERO_M;
                                r_done  <= 1'b1;
                                r_state <= S_IDLE;
                            end else begin
                                r_blk   <= r_blk + ONE_M;
                                r_state <= w_full_rel[~r_buf_sel] ? S_WAIT_BUF : S_WRITE;
                            end
                        end else begin
                            r_state <= S_WRITE;
                        end
                    end else begin
                        r_state <= S_WRITE;
                    end
                end
                S_WAIT_BUF: begin
                    if (!w_full_rel[r_buf_sel]) begin
                        r_state <= S_WRITE;
                    end else begin
                        r_state <= S_WAIT_BUF;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Bank write port, launched one cycle after each accepted beat
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_addr  <= {ADDR_W{1'b0}};
            r_wr_data  <= {DATA_W{1'b0}};
            r_activate <= {N2{1'b0}};
        end else if (w_accept) begin
            r_wr_addr  <= w_addr;
            r_wr_data  <= data_B;
            r_activate <= f_onehot(r_col);
        end else begin
            r_activate <= {N2{1'b0}};
        end
    end
endmodule

// File: tb/tb_mem_write_b_ppx.sv
// Directed bench for mem_write_b_ppx: expected bank writes are queued as beats
// are driven and compared when the write appears on the bank port.
module tb_mem_write_b_ppx;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] M2 = 16'd0, BLOCK_WIDTHdN2 = 16'd0, BLOCK_NUM = 16'd0;
    logic        valid_B = 1'b0;
    logic [7:0]  data_B = 8'd0;
    logic        ready_B;
    logic [1:0]  buf_release = 2'b00;
    logic [11:0] wr_addr_B;
    logic [7:0]  wr_data_B;
    logic [3:0]  activate_B;
    logic [1:0]  buf_done;
    logic        busy, done, cfg_err;

    typedef struct packed {
        logic [11:0] a;
        logic [3:0]  act;
        logic [7:0]  d;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          failures = 0;
    logic [7:0]  tb_d = 8'h11;
    bit          tb_acc = 1'b0;

    mem_write_b_ppx #(.N2(4), .MATRIXSIZE_W(16), .ADDR_W(12), .DATA_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .M2(M2), .BLOCK_WIDTHdN2(BLOCK_WIDTHdN2),
        .BLOCK_NUM(BLOCK_NUM), .valid_B(valid_B), .data_B(data_B), .ready_B(ready_B),
        .buf_release(buf_release), .wr_addr_B(wr_addr_B), .wr_data_B(wr_data_B),
        .activate_B(activate_B), .buf_done(buf_done), .busy(busy), .done(done),
        .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) tb_acc = valid_B && ready_B && !rst;

    always @(negedge clk) begin
        exp_t e;
        if (tb_acc) begin
            chk("q_nonempty", (q.size() == 0) ? 32'd0 : 32'd1, 32'd1);
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("wr_addr", {20'd0, wr_addr_B}, {20'd0, e.a});
                chk("activate", {28'd0, activate_B}, {28'd0, e.act});
                chk("wr_data", {24'd0, wr_data_B}, {24'd0, e.d});
            end
        end else begin
            chk("act_idle", {28'd0, activate_B}, 32'd0);
        end
    end

    task automatic send_beat(input logic [11:0] a, input logic [3:0] act);
        bit ok = 1'b0;
        exp_t e;
        tb_d    = tb_d + 8'h2B;
        valid_B = 1'b1;
        data_B  = tb_d;
        e.a = a; e.act = act; e.d = tb_d;
        q.push_back(e);
        for (int n = 0; n < 40 && !ok; n++) begin
            ok = ready_B;
            @(negedge clk);
        end
        valid_B = 1'b0;
        if (!ok) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_block(input bit sel, input bit last, input int gap, input int m2, input int bw);
        logic [10:0] lo;
        for (int r = 0; r < m2; r++)
            for (int p = 0; p < bw; p++)
                for (int c = 0; c < 4; c++) begin
                    lo = 11'(r + p * m2);
                    send_beat({sel, lo}, 4'(1 << c));
                    if (r == m2 - 1 && p == bw - 1 && c == 3) begin
                        chk("buf_done_pulse", {30'd0, buf_done}, sel ? 32'd2 : 32'd1);
                        chk("done_pulse", {31'd0, done}, {31'd0, last});
                    end else begin
                        chk("buf_done_quiet", {30'd0, buf_done}, 32'd0);
                    end
                    for (int g = 0; g < gap; g++) @(negedge clk);
                end
    endtask

    task automatic do_start(input logic [15:0] m2, input logic [15:0] bw, input logic [15:0] bn);
        M2 = m2; BLOCK_WIDTHdN2 = bw; BLOCK_NUM = bn;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic release_half(input logic [1:0] rel);
        buf_release = rel;
        @(negedge clk);
        buf_release = 2'b00;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_ready"}, {31'd0, ready_B}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_addr"}, {20'd0, wr_addr_B}, 32'd0);
        chk({tag, "_data"}, {24'd0, wr_data_B}, 32'd0);
        chk({tag, "_act"}, {28'd0, activate_B}, 32'd0);
        chk({tag, "_bufdone"}, {30'd0, buf_done}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
        chk({tag, "_cfgerr"}, {31'd0, cfg_err}, 32'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // single block, continuous valid
        do_start(16'd2, 16'd2, 16'd1);
        chk("t1_busy", {31'd0, busy}, 32'd1);
        chk("t1_ready", {31'd0, ready_B}, 32'd1);
        send_block(1'b0, 1'b1, 0, 2, 2);
        @(negedge clk);
        chk("t1_idle_busy", {31'd0, busy}, 32'd0);
        chk("t1_done_clear", {31'd0, done}, 32'd0);
        release_half(2'b01);

        // three blocks, ping/pong with stall on the full half
        do_start(16'd2, 16'd2, 16'd3);
        send_block(1'b0, 1'b0, 0, 2, 2);
        chk("t2_ready_pong", {31'd0, ready_B}, 32'd1);
        send_block(1'b1, 1'b0, 0, 2, 2);
        chk("t2_wait_ready", {31'd0, ready_B}, 32'd0);
        chk("t2_wait_busy", {31'd0, busy}, 32'd1);
        valid_B = 1'b1;
        repeat (3) @(negedge clk);
        chk("t2_still_wait", {31'd0, ready_B}, 32'd0);
        valid_B = 1'b0;
        release_half(2'b01);
        chk("t2_resume", {31'd0, ready_B}, 32'd1);
        send_block(1'b0, 1'b1, 0, 2, 2);
        @(negedge clk);
        chk("t2_idle", {31'd0, busy}, 32'd0);
        release_half(2'b11);

        // throttled valid: one idle cycle after every beat
        do_start(16'd2, 16'd2, 16'd1);
        send_block(1'b0, 1'b1, 1, 2, 2);
        chk("t3_idle", {31'd0, busy}, 32'd0);
        release_half(2'b01);

        // config rejection and the exact-fit boundary
        do_start(16'd0, 16'd2, 16'd1);
        chk("t4_err_zero", {31'd0, cfg_err}, 32'd1);
        chk("t4_busy_zero", {31'd0, busy}, 32'd0);
        @(negedge clk);
        chk("t4_err_pulse", {31'd0, cfg_err}, 32'd0);
        do_start(16'd64, 16'd64, 16'd1);
        chk("t4_err_big", {31'd0, cfg_err}, 32'd1);
        chk("t4_busy_big", {31'd0, busy}, 32'd0);
        @(negedge clk);
        do_start(16'd64, 16'd32, 16'd1);
        chk("t4_fit_err", {31'd0, cfg_err}, 32'd0);
        chk("t4_fit_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t4_reset_busy", {31'd0, busy}, 32'd0);

        // reset in the middle of a block, then restart
        do_start(16'd2, 16'd2, 16'd1);
        send_beat(12'h000, 4'b0001);
        send_beat(12'h000, 4'b0010);
        send_beat(12'h000, 4'b0100);
        send_beat(12'h000, 4'b1000);
        send_beat(12'h002, 4'b0001);
        send_beat(12'h002, 4'b0010);
        send_beat(12'h002, 4'b0100);
        rst = 1'b1;
        valid_B = 1'b1;
        data_B = 8'hA5;
        @(negedge clk);
        valid_B = 1'b0;
        check_all_zero("t5_rst");
        rst = 1'b0;
        @(negedge clk);
        do_start(16'd2, 16'd2, 16'd1);
        send_block(1'b0, 1'b1, 0, 2, 2);
        @(negedge clk);

        chk("q_drained", q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
